call_ret_ctrl: RTL and testbench



---
 rtl/call_ret_pkg.sv | 17 +
 rtl/call_ret_ctrl_if.sv | 47 ++++
 rtl/call_depth_ctr.sv | 26 ++
 rtl/call_ret_ctrl.sv | 121 ++++++++++++
 tb/tb_call_ret_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/call_ret_pkg.sv
// Shared types for the CALL/RET controller: FSM state encoding and fault codes.
package call_ret_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP   = 3'd2,
    JUMP  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] F_NONE     = 2'd0;
  localparam logic [1:0] F_OVF      = 2'd1;
  localparam logic [1:0] F_UNF      = 2'd2;
  localparam logic [1:0] F_CONFLICT = 2'd3;

endpackage

// File: rtl/call_ret_ctrl_if.sv
// Decode, LIFO and PC-side signals of the CALL/RET controller.
// The depth signal exists only when CALL_RET_DEPTH_TRACK_EN is defined.
interface call_ret_ctrl_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 16
);
  logic              call_req;
  logic              ret_req;
  logic [ADDR_W-1:0] pc_cur;
  logic [ADDR_W-1:0] call_target;
  logic              fault_clr;
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_wdata;
  logic [ADDR_W-1:0] stk_rdata;
  logic              stk_empty;
  logic              stk_full;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;
  logic              busy;
  logic              fault;
  logic [1:0]        fault_code;
`ifdef CALL_RET_DEPTH_TRACK_EN
  logic [$clog2(STACK_DEPTH):0] depth;
`endif

  modport master (
    input  call_req, ret_req, pc_cur, call_target, fault_clr,
    input  stk_rdata, stk_empty, stk_full,
    output stk_push, stk_pop, stk_wdata,
    output pc_load, pc_next, busy, fault, fault_code
`ifdef CALL_RET_DEPTH_TRACK_EN
    , output depth
`endif
  );

  modport slave (
    output call_req, ret_req, pc_cur, call_target, fault_clr,
    output stk_rdata, stk_empty, stk_full,
    input  stk_push, stk_pop, stk_wdata,
    input  pc_load, pc_next, busy, fault, fault_code
`ifdef CALL_RET_DEPTH_TRACK_EN
    , input depth
`endif
  );

endinterface

// File: rtl/call_depth_ctr.sv
// Up/down occupancy counter mirroring the return-address LIFO depth.
module call_depth_ctr #(
  parameter int DEPTH_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth
);

  logic [DEPTH_W-1:0] depth_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_reg <= '0;
    end else if (inc && !dec) begin
      depth_reg <= depth_reg + 1'b1;
    end else if (dec && !inc) begin
      depth_reg <= depth_reg - 1'b1;
    end
  end

  assign depth = depth_reg;

endmodule

// File: rtl/call_ret_ctrl.sv
// CALL/RET controller driving the return-address LIFO and the PC load strobe.
// Define CALL_RET_DEPTH_TRACK_EN to track depth internally and cross-check the LIFO flags.
module call_ret_ctrl
  import call_ret_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  call_ret_ctrl_if.master bus
);

  state_t            state_reg, state_next;
  logic [1:0]        fault_code_reg, fault_code_next;
  logic [ADDR_W-1:0] ret_addr_reg;
  logic [ADDR_W-1:0] target_reg;
  logic [ADDR_W-1:0] pc_hold_reg;
  logic              latch_call;
  logic              ovf, unf, flag_err;

  if (STACK_DEPTH < 1) begin : g_depth_chk
    $error("STACK_DEPTH must be positive");
  end

`ifdef CALL_RET_DEPTH_TRACK_EN
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;
  logic [DEPTH_W-1:0] depth_val;

  call_depth_ctr #(.DEPTH_W(DEPTH_W)) u_depth (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_reg == PUSH),
    .dec   (state_reg == POP),
    .depth (depth_val)
  );

  assign ovf       = (depth_val == DEPTH_W'(STACK_DEPTH));
  assign unf       = (depth_val == '0);
  // The tracker and the LIFO must agree; a disagreement means lost strobes.
  assign flag_err  = (ovf != bus.stk_full) || (unf != bus.stk_empty);
  assign bus.depth = depth_val;
`else
  assign ovf      = bus.stk_full;
  assign unf      = bus.stk_empty;
  assign flag_err = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    latch_call      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flag_err || (bus.call_req && bus.ret_req)) begin
          state_next      = FAULT;
          fault_code_next = F_CONFLICT;
        end else if (bus.call_req) begin
          if (ovf) begin
            state_next      = FAULT;
            fault_code_next = F_OVF;
          end else begin
            state_next = PUSH;
            latch_call = 1'b1;
          end
        end else if (bus.ret_req) begin
          if (unf) begin
            state_next      = FAULT;
            fault_code_next = F_UNF;
          end else begin
            state_next = POP;
          end
        end
      end
      PUSH:  state_next = JUMP;
      POP:   state_next = JUMP;
      JUMP:  state_next = IDLE;
      FAULT: begin
        if (bus.fault_clr) begin
          state_next      = IDLE;
          fault_code_next = F_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      fault_code_reg <= F_NONE;
      ret_addr_reg   <= '0;
      target_reg     <= '0;
      pc_hold_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
      if (latch_call) begin
        ret_addr_reg <= bus.pc_cur + {{(ADDR_W-1){1'b0}}, 1'b1};
        target_reg   <= bus.call_target;
      end
      if (state_reg == POP) begin
        target_reg <= bus.stk_rdata;
      end
      // Remember the last jump so pc_next stays put between jumps.
      if (state_reg == JUMP) begin
        pc_hold_reg <= target_reg;
      end
    end
  end

  assign bus.stk_push   = (state_reg == PUSH);
  assign bus.stk_pop    = (state_reg == POP);
  assign bus.stk_wdata  = ret_addr_reg;
  assign bus.pc_load    = (state_reg == JUMP);
  assign bus.pc_next    = (state_reg == JUMP) ? target_reg : pc_hold_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.fault      = (state_reg == FAULT);
  assign bus.fault_code = fault_code_reg;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Directed bench for call_ret_ctrl with a behavioural 16-entry LIFO and a scoreboard queue.
module tb_call_ret_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  call_ret_ctrl_if #(.ADDR_W(8), .STACK_DEPTH(16)) bus ();

  call_ret_ctrl #(.ADDR_W(8), .STACK_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural LIFO with registered occupancy, sharing rst with the DUT.
  logic [7:0] mem [0:15];
  logic [4:0] cnt;
  always @(posedge clk) begin
    if (rst) begin
      cnt <= 5'd0;
    end else if (bus.stk_push && cnt < 5'd16) begin
      mem[cnt[3:0]] <= bus.stk_wdata;
      cnt <= cnt + 5'd1;
    end else if (bus.stk_pop && cnt > 5'd0) begin
      cnt <= cnt - 5'd1;
    end
  end
  logic [4:0] top_idx;
  assign top_idx       = cnt - 5'd1;
  assign bus.stk_rdata = (cnt == 5'd0) ? 8'h00 : mem[top_idx[3:0]];
  assign bus.stk_empty = (cnt == 5'd0);
  assign bus.stk_full  = (cnt == 5'd16);

  typedef struct {
    logic       is_call;
    logic [7:0] wdata;
    logic [7:0] pc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] shadow[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] pc_exp);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " strobes"}, {29'd0, bus.stk_push, bus.stk_pop, bus.pc_load}, 32'd0);
    chk({tag, " fault"}, {29'd0, bus.fault, bus.fault_code}, 32'd0);
    chk({tag, " pc_next"}, 32'(bus.pc_next), 32'(pc_exp));
  endtask

  task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt);
    exp_t e;
    e.is_call = 1'b1;
    e.wdata   = pc + 8'd1;
    e.pc      = tgt;
    exp_q.push_back(e);
    shadow.push_back(pc + 8'd1);
    @(negedge clk);
    bus.call_req = 1'b1; bus.pc_cur = pc; bus.call_target = tgt;
    @(negedge clk);
    bus.call_req = 1'b0;
    chk("call push", {30'd0, bus.stk_push, bus.stk_pop}, 32'd2);
    chk("call wdata", 32'(bus.stk_wdata), 32'(exp_q[0].wdata));
    chk("call busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("call pc_load", {30'd0, bus.pc_load, bus.stk_push}, 32'd2);
    chk("call pc_next", 32'(bus.pc_next), 32'(e.pc));
    @(negedge clk);
    chk_idle("call done", e.pc);
    $display("CALL pc=%02h tgt=%02h ret=%02h depth=%0d", pc, tgt, e.wdata, cnt);
  endtask

  task automatic do_ret();
    exp_t e;
    e.is_call = 1'b0;
    e.wdata   = 8'h00;
    e.pc      = shadow.pop_back();
    exp_q.push_back(e);
    @(negedge clk);
    bus.ret_req = 1'b1;
    @(negedge clk);
    bus.ret_req = 1'b0;
    chk("ret pop", {30'd0, bus.stk_push, bus.stk_pop}, 32'd1);
    chk("ret busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("ret pc_load", {30'd0, bus.pc_load, bus.stk_pop}, 32'd2);
    chk("ret pc_next", 32'(bus.pc_next), 32'(e.pc));
    @(negedge clk);
    chk_idle("ret done", e.pc);
    $display("RET  pc_next=%02h depth=%0d", e.pc, cnt);
  endtask

  task automatic do_fault(input logic c, input logic r, input logic [1:0] code, input logic [7:0] pc_keep);
    @(negedge clk);
    bus.call_req = c; bus.ret_req = r;
    @(negedge clk);
    bus.call_req = 1'b0; bus.ret_req = 1'b0;
    chk("fault state", {30'd0, bus.fault, bus.busy}, 32'd3);
    chk("fault code", 32'(bus.fault_code), 32'(code));
    chk("fault strobes", {29'd0, bus.stk_push, bus.stk_pop, bus.pc_load}, 32'd0);
    @(negedge clk);
    chk("fault sticky", {29'd0, bus.fault, bus.fault_code}, {29'd0, 1'b1, code});
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    chk_idle("fault clr", pc_keep);
    $display("FAULT req=%b%b code=%0d cleared", c, r, code);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    shadow.delete();
    exp_q.delete();
    chk_idle("reset", 8'h00);
    chk("reset empty", 32'(bus.stk_empty), 32'd1);
    $display("RESET");
  endtask

  initial begin
    exp_t e;
    bus.call_req = 1'b0; bus.ret_req = 1'b0; bus.fault_clr = 1'b0;
    bus.pc_cur = 8'h00; bus.call_target = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle("post reset", 8'h00);

    do_call(8'h10, 8'h40);
    do_ret();
    chk("empty after ret", 32'(bus.stk_empty), 32'd1);

    for (int i = 0; i < 16; i++) begin
      do_call(8'(i * 4), 8'(8'h80 + i));
    end
    chk("full after 16", 32'(bus.stk_full), 32'd1);
    do_fault(1'b1, 1'b0, 2'd1, 8'h8F);
    chk("no push on ovf", 32'(cnt), 32'd16);

    do_reset();
    do_fault(1'b0, 1'b1, 2'd2, 8'h00);
    chk("no pop on unf", 32'(cnt), 32'd0);

    do_call(8'hFF, 8'h22);
    do_ret();
    do_fault(1'b1, 1'b1, 2'd3, 8'h00);
    chk("no access on conflict", 32'(cnt), 32'd0);

    // A CALL held high through the busy cycles must not start a second one.
    e.is_call = 1'b1; e.wdata = 8'h31; e.pc = 8'h50;
    exp_q.push_back(e);
    shadow.push_back(8'h31);
    @(negedge clk);
    bus.call_req = 1'b1; bus.pc_cur = 8'h30; bus.call_target = 8'h50;
    @(negedge clk);
    bus.pc_cur = 8'h77; bus.call_target = 8'h99;
    chk("busy call push", 32'(bus.stk_wdata), 32'(exp_q[0].wdata));
    @(negedge clk);
    e = exp_q.pop_front();
    chk("busy call pc_next", {23'd0, bus.pc_load, bus.pc_next}, {23'd0, 1'b1, e.pc});
    @(negedge clk);
    bus.call_req = 1'b0;
    chk_idle("busy call end", 8'h50);
    @(negedge clk);
    chk_idle("busy call ignored", 8'h50);
    chk("busy call depth", 32'(cnt), 32'd1);
    $display("CALL while busy ignored depth=%0d", cnt);
    do_ret();

    // Reset during the push cycle.
    @(negedge clk);
    bus.call_req = 1'b1; bus.pc_cur = 8'h05; bus.call_target = 8'h60;
    @(negedge clk);
    bus.call_req = 1'b0;
    chk("rst push active", 32'(bus.stk_push), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst in push", 8'h00);
    $display("RESET during PUSH");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
